// File: rtl/factor_pkg.sv
// Shared FSM state encoding and factorisation mode constants for factor_streamer.
package factor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_EMIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic MODE_ALL   = 1'b0;
  localparam logic MODE_PRIME = 1'b1;

endpackage

// File: rtl/trial_divider.sv
// Repeated-subtraction datapath: remainder r and quotient q for the current trial divisor.
module trial_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             step,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic             ge,
  output logic             r_zero
);

  // One extra bit so a divisor equal to 2^WIDTH still compares correctly.
  assign ge     = ({1'b0, r} >= divisor);
  assign r_zero = (r == {WIDTH{1'b0}});

  always_ff @(posedge clk) begin
    if (reset) begin
      r <= {WIDTH{1'b0}};
      q <= {WIDTH{1'b0}};
    end else if (load) begin
      r <= load_value;
      q <= {WIDTH{1'b0}};
    end else if (step && ge) begin
      r <= r - divisor[WIDTH-1:0];
      q <= q + WIDTH'(1);
    end else begin
      r <= r;
      q <= q;
    end
  end

endmodule

// File: rtl/factor_streamer.sv
// Streams the divisors (mode 0) or prime factors (mode 1) of a number by trial division,
// ending every list with one marker beat that carries the residual cofactor.
module factor_streamer
  import factor_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int DIV_MAX = 19,
  localparam int DIV_W   = $clog2(DIV_MAX + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_number,
  input  logic             in_mode,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIV_W-1:0] out_divisor,
  output logic             out_last,
  output logic [WIDTH-1:0] out_cofactor,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] n;
  logic             mode;
  logic [DIV_W-1:0] d;
  logic [DIV_W-1:0] d_inc;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic             ge;
  logic             r_zero;
  logic             dv_load;
  logic [WIDTH-1:0] dv_value;
  logic             dv_step;

  function automatic logic term_check(input logic [WIDTH-1:0] num,
                                      input logic [DIV_W-1:0] div,
                                      input logic             md);
    logic [WIDTH:0] num_x;
    logic [WIDTH:0] div_x;
    logic           hit;
    num_x = (WIDTH+1)'(num);
    div_x = (WIDTH+1)'(div);
    hit   = (div_x > (WIDTH+1)'(DIV_MAX));
    if (md == MODE_ALL) begin
      hit = hit | ((num != {WIDTH{1'b0}}) && (div_x > num_x));
    end else begin
      hit = hit | (num_x <= (WIDTH+1)'(1));
    end
    return hit;
  endfunction

  assign d_inc = d + DIV_W'(1);
  assign d_ext = (WIDTH+1)'(d);

  trial_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .reset      (reset),
    .load       (dv_load),
    .load_value (dv_value),
    .step       (dv_step),
    .divisor    (d_ext),
    .r          (r),
    .q          (q),
    .ge         (ge),
    .r_zero     (r_zero)
  );

  // Datapath reload/step requests; reloads mirror the FSM transitions below.
  always_comb begin
    dv_load  = 1'b0;
    dv_value = n;
    dv_step  = 1'b0;
    if (!reset && !abort) begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            dv_load  = 1'b1;
            dv_value = in_number;
          end else begin
            dv_load = 1'b0;
          end
        end
        ST_DIVIDE: begin
          if (ge) begin
            dv_step = 1'b1;
          end else if (!r_zero) begin
            dv_load = 1'b1;
          end else begin
            dv_load = 1'b0;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            dv_load  = 1'b1;
            dv_value = (mode == MODE_PRIME) ? q : n;
          end else begin
            dv_load = 1'b0;
          end
        end
        default: begin
          dv_load = 1'b0;
        end
      endcase
    end else begin
      dv_load = 1'b0;
    end
  end

  // Control FSM; in prime mode the quotient becomes the new number and d is retried.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      n     <= {WIDTH{1'b0}};
      mode  <= MODE_ALL;
      d     <= DIV_W'(2);
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            n     <= in_number;
            mode  <= in_mode;
            d     <= DIV_W'(2);
            state <= term_check(in_number, DIV_W'(2), in_mode) ? ST_FINISH : ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (!ge) begin
            if (r_zero) begin
              state <= ST_EMIT;
            end else begin
              d     <= d_inc;
              state <= term_check(n, d_inc, mode) ? ST_FINISH : ST_DIVIDE;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (mode == MODE_PRIME) begin
              n     <= q;
              state <= term_check(q, d, mode) ? ST_FINISH : ST_DIVIDE;
            end else begin
              d     <= d_inc;
              state <= term_check(n, d_inc, mode) ? ST_FINISH : ST_DIVIDE;
            end
          end
        end
        ST_FINISH: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = (state == ST_IDLE) && !abort;
  assign busy         = (state != ST_IDLE);
  assign out_valid    = (state == ST_EMIT) || (state == ST_FINISH);
  assign out_last     = (state == ST_FINISH);
  assign out_divisor  = (state == ST_EMIT) ? d : {DIV_W{1'b0}};
  assign out_cofactor = ((state == ST_FINISH) && (mode == MODE_PRIME)) ? n : {WIDTH{1'b0}};

endmodule

// File: tb/tb_factor_streamer.sv
// Scoreboard bench for factor_streamer: directed jobs push expected beats, monitors pop on handshakes.
module tb_factor_streamer;

  typedef struct {
    int div;
    int last;
    int cof;
  } beat_t;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_number;
  logic       in_mode;
  logic       abort;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_divisor;
  logic       out_last;
  logic [7:0] out_cofactor;
  logic       busy;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [11:0] w_in_number;
  logic        w_in_mode;
  logic        w_abort;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [5:0]  w_out_divisor;
  logic        w_out_last;
  logic [11:0] w_out_cofactor;
  logic        w_busy;

  int    checks = 0;
  int    errors = 0;
  int    markers = 0;
  int    w_markers = 0;
  int    ready_mode = 1;
  beat_t sb[$];
  beat_t w_sb[$];

  logic       stall_prev = 1'b0;
  logic [4:0] held_div;
  logic       held_last;
  logic [7:0] held_cof;

  factor_streamer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_number(in_number), .in_mode(in_mode), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .out_divisor(out_divisor), .out_last(out_last),
    .out_cofactor(out_cofactor), .busy(busy)
  );

  factor_streamer #(.WIDTH(12), .DIV_MAX(31)) dut_wide (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_number(w_in_number), .in_mode(w_in_mode), .abort(w_abort), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_divisor(w_out_divisor), .out_last(w_out_last),
    .out_cofactor(w_out_cofactor), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int dv, input int lst, input int cof);
    beat_t b;
    b.div = dv; b.last = lst; b.cof = cof;
    sb.push_back(b);
  endtask

  // Main-instance monitor: scoreboard pop, stall stability and quiet-output checks.
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_divisor", out_divisor, held_div);
        check("stall_last", out_last, held_last);
        check("stall_cofactor", out_cofactor, held_cof);
      end
      if (!out_valid) begin
        check("idle_outputs_zero", {out_divisor, out_last, out_cofactor}, 0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat_divisor", out_divisor, 999);
        end else begin
          e = sb.pop_front();
          check("beat_divisor", int'(out_divisor), e.div);
          check("beat_last", int'(out_last), e.last);
          check("beat_cofactor", int'(out_cofactor), e.cof);
        end
        if (out_last) markers++;
      end
    end
    stall_prev = out_valid && !out_ready && !abort && !reset;
    held_div   = out_divisor;
    held_last  = out_last;
    held_cof   = out_cofactor;
  end

  // Wide-instance monitor.
  always @(negedge clk) begin
    beat_t e;
    if (!reset && w_out_valid && w_out_ready) begin
      if (w_sb.size() == 0) begin
        check("wide_unexpected_beat", w_out_divisor, 999);
      end else begin
        e = w_sb.pop_front();
        check("wide_beat_divisor", int'(w_out_divisor), e.div);
        check("wide_beat_last", int'(w_out_last), e.last);
        check("wide_beat_cofactor", int'(w_out_cofactor), e.cof);
      end
      if (w_out_last) w_markers++;
    end
  end

  task automatic start_req(input logic [7:0] num, input logic md);
    @(posedge clk); #1;
    in_valid = 1'b1; in_number = num; in_mode = md;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(posedge clk); #1; cnt++;
    end
    check("reached_output", out_valid, 1);
  endtask

  // lat_exp > 0: number of edges after the accept edge before out_valid is seen.
  task automatic run_job(input logic [7:0] num, input logic md, input int lat_exp);
    int start = markers;
    int cnt = 0;
    start_req(num, md);
    if (lat_exp > 0) begin
      while (!out_valid && cnt < 100) begin
        @(posedge clk); #1; cnt++;
      end
      check("first_out_valid_latency", cnt, lat_exp);
    end
    cnt = 0;
    while (markers == start && cnt < 2000) begin
      @(posedge clk); #2; cnt++;
    end
    check("job_completed", markers - start, 1);
    check("in_ready_after_marker", in_ready, 1);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    int cnt;
    beat_t b;
    reset = 1'b1; in_valid = 1'b0; in_number = 8'd0; in_mode = 1'b0; abort = 1'b0;
    w_in_valid = 1'b0; w_in_number = 12'd0; w_in_mode = 1'b0; w_abort = 1'b0; w_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("post_reset_out_valid", out_valid, 0);
    check("post_reset_busy", busy, 0);
    check("post_reset_in_ready", in_ready, 1);

    // n=12 all divisors; 7 DIVIDE cycles for d=2, so out_valid in the 8th cycle after accept.
    push(2, 0, 0); push(3, 0, 0); push(4, 0, 0); push(6, 0, 0); push(12, 0, 0); push(0, 1, 0);
    run_job(8'd12, 1'b0, 7);

    push(2, 0, 0); push(2, 0, 0); push(3, 0, 0); push(0, 1, 1);
    run_job(8'd12, 1'b1, 0);
    push(2, 0, 0); push(0, 1, 47);
    run_job(8'd94, 1'b1, 0);

    for (int k = 2; k <= 19; k++) push(k, 0, 0);
    push(0, 1, 0);
    run_job(8'd0, 1'b0, 0);

    push(0, 1, 0);
    run_job(8'd1, 1'b0, 0);
    push(0, 1, 1);
    run_job(8'd1, 1'b1, 0);
    push(0, 1, 0);
    run_job(8'd0, 1'b1, 0);

    // Random back-pressure.
    ready_mode = 2;
    push(2, 0, 0); push(3, 0, 0); push(4, 0, 0); push(6, 0, 0); push(12, 0, 0); push(0, 1, 0);
    run_job(8'd12, 1'b0, 0);
    ready_mode = 1;

    // Abort in DIVIDE.
    start_req(8'd200, 1'b0);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    check("abort_divide_busy_before", busy, 1);
    @(posedge clk); #1;
    check("abort_divide_busy", busy, 0);
    check("abort_divide_out_valid", out_valid, 0);
    check("in_ready_during_abort", in_ready, 0);
    abort = 1'b0;
    #1 check("in_ready_after_abort", in_ready, 1);

    // Abort in EMIT while stalled.
    ready_mode = 0;
    start_req(8'd12, 1'b0);
    wait_out_valid();
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    check("abort_emit_out_valid", out_valid, 0);
    check("abort_emit_busy", busy, 0);
    abort = 1'b0;
    ready_mode = 1;

    // Abort together with a request in IDLE.
    @(posedge clk); #1;
    in_valid = 1'b1; in_number = 8'd12; in_mode = 1'b0; abort = 1'b1;
    #1 check("abort_masks_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    check("abort_idle_not_accepted", busy, 0);
    repeat (3) @(posedge clk);
    #1 check("abort_idle_still_idle", busy, 0);
    check("abort_idle_out_valid", out_valid, 0);

    push(3, 0, 0); push(5, 0, 0); push(0, 1, 1);
    run_job(8'd15, 1'b1, 0);

    // Reset during EMIT.
    ready_mode = 0;
    start_req(8'd12, 1'b0);
    wait_out_valid();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    check("reset_emit_out_valid", out_valid, 0);
    check("reset_emit_busy", busy, 0);
    reset = 1'b0;
    #1 check("reset_emit_in_ready", in_ready, 1);
    ready_mode = 1;

    // Wide instance: 4094 = 2 * 23 * 89 with DIV_MAX = 31.
    b.div = 2;  b.last = 0; b.cof = 0;  w_sb.push_back(b);
    b.div = 23; b.last = 0; b.cof = 0;  w_sb.push_back(b);
    b.div = 0;  b.last = 1; b.cof = 89; w_sb.push_back(b);
    @(posedge clk); #1;
    w_in_valid = 1'b1; w_in_number = 12'd4094; w_in_mode = 1'b1;
    check("wide_in_ready", w_in_ready, 1);
    @(posedge clk); #1 w_in_valid = 1'b0;
    cnt = 0;
    while (w_markers == 0 && cnt < 20000) begin
      @(posedge clk); #2; cnt++;
    end
    check("wide_job_completed", w_markers, 1);
    check("wide_scoreboard_drained", w_sb.size(), 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
